// File: rtl/comment_strip.sv
// comment_strip: removes C comments from a byte stream ahead of the int-declaration checker.
// Define COMMENT_STRIP_LINE_EN to also strip // line comments; /* */ is always stripped.
module comment_strip #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_char,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_char,
    output logic             out_valid,
    output logic             in_comment,
    output logic [CNT_W-1:0] comment_cnt
);

    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_SP    = 8'h20;

    typedef enum logic [2:0] {
        NORMAL = 3'd0,
        SLASH  = 3'd1,
        LINE   = 3'd2,
        BLOCK  = 3'd3,
        BSTAR  = 3'd4,
        FLUSH  = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] held;

    // A transfer happens when in_valid && in_ready. in_ready drops only in FLUSH,
    // while the character that followed a lone '/' is replayed; the source holds its data.
    assign in_ready = (state != FLUSH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= NORMAL;
            held        <= 8'h00;
            out_char    <= 8'h00;
            out_valid   <= 1'b0;
            in_comment  <= 1'b0;
            comment_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == FLUSH) begin
                // held is emitted verbatim, never re-examined as a comment opener
                out_char  <= held;
                out_valid <= 1'b1;
                state     <= NORMAL;
            end else if (in_valid) begin
                case (state)
                    NORMAL: begin
                        if (in_char == CH_SLASH) begin
                            state <= SLASH;
                        end else begin
                            out_char  <= in_char;
                            out_valid <= 1'b1;
                        end
                    end
                    SLASH: begin
                        if (in_char == CH_STAR) begin
                            state      <= BLOCK;
                            in_comment <= 1'b1;
                        end
`ifdef COMMENT_STRIP_LINE_EN
                        else if (in_char == CH_SLASH) begin
                            state      <= LINE;
                            in_comment <= 1'b1;
                        end
`endif
                        else begin
                            out_char  <= CH_SLASH;
                            out_valid <= 1'b1;
                            held      <= in_char;
                            state     <= FLUSH;
                        end
                    end
                    BLOCK: begin
                        if (in_char == CH_STAR) state <= BSTAR;
                    end
                    BSTAR: begin
                        if (in_char == CH_SLASH) begin
                            out_char   <= CH_SP;
                            out_valid  <= 1'b1;
                            state      <= NORMAL;
                            in_comment <= 1'b0;
                            if (comment_cnt != '1) comment_cnt <= comment_cnt + CNT_W'(1);
                        end else if (in_char != CH_STAR) begin
                            state <= BLOCK;
                        end
                    end
`ifdef COMMENT_STRIP_LINE_EN
                    LINE: begin
                        if (in_char == CH_NL) begin
                            out_char   <= CH_NL;
                            out_valid  <= 1'b1;
                            state      <= NORMAL;
                            in_comment <= 1'b0;
                            if (comment_cnt != '1) comment_cnt <= comment_cnt + CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                        state      <= NORMAL;
                        in_comment <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_comment_strip.sv
// Bench for comment_strip: directed tables, multi-cycle corner sequences and random streams
// checked against a string-level comment-removal model.
module tb_comment_strip;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       in_char = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       out_char;
    logic             out_valid;
    logic             in_comment;
    logic [CNT_W-1:0] comment_cnt;

    comment_strip #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_char(in_char), .in_valid(in_valid),
        .in_ready(in_ready), .out_char(out_char), .out_valid(out_valid),
        .in_comment(in_comment), .comment_cnt(comment_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];
    int exp_cnt;

    always @(negedge clk) begin
        if (!reset && out_valid) got_q.push_back(out_char);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name);
        int diff;
        int gv;
        int ev;
        diff = -1;
        n_total++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (diff < 0 && got_q[i] !== exp_q[i]) diff = i;
        if (diff < 0 && got_q.size() != exp_q.size())
            diff = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        if (diff >= 0) begin
            gv = (diff < got_q.size()) ? int'(got_q[diff]) : -1;
            ev = (diff < exp_q.size()) ? int'(exp_q[diff]) : -1;
            n_bad++;
            $display("FAIL %s: stream differs at index %0d got=%0h expected=%0h (got %0d chars, expected %0d)",
                     name, diff, gv, ev, got_q.size(), exp_q.size());
        end
    endtask

    // driver tasks
    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the accepting edge, with in_valid still high.
    task automatic send(input logic [7:0] c);
        bit acc;
        acc = 1'b0;
        in_char = c;
        in_valid = 1'b1;
        for (int t = 0; t < 4 && !acc; t++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            n_bad++;
            $display("FAIL accept_timeout: char=%0h never accepted", c);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic str_to_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Reference: walk the whole text, replace each complete comment by its
    // collapse character; an incomplete opener/comment at the end yields nothing.
    function automatic void model();
        int i;
        int n;
        int j;
        bit found;
        i = 0;
        n = stim_q.size();
        exp_q.delete();
        exp_cnt = 0;
        while (i < n) begin
            if (stim_q[i] != "/") begin
                exp_q.push_back(stim_q[i]);
                i++;
            end else if (i + 1 >= n) begin
                break;
            end else if (stim_q[i+1] == "*") begin
                j = i + 2;
                found = 1'b0;
                while (j + 1 < n && !found) begin
                    if (stim_q[j] == "*" && stim_q[j+1] == "/") found = 1'b1;
                    else j++;
                end
                if (!found) break;
                exp_q.push_back(8'h20);
                exp_cnt++;
                i = j + 2;
            end
`ifdef COMMENT_STRIP_LINE_EN
            else if (stim_q[i+1] == "/") begin
                j = i + 2;
                while (j < n && stim_q[j] != 8'h0A) j++;
                if (j >= n) break;
                exp_q.push_back(8'h0A);
                exp_cnt++;
                i = j + 1;
            end
`endif
            else begin
                exp_q.push_back(stim_q[i]);
                exp_q.push_back(stim_q[i+1]);
                i += 2;
            end
        end
    endfunction

    typedef struct {
        string name;
        string stim;
        string exp;
        int    cnt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [7:0] alpha[5];
        int len;
        string nl_blk;

        nl_blk = {"/*", "\n", "*/"};

        vecs[0] = '{"plain", "int a;", "int a;", 0};
        vecs[1] = '{"lone_slash", "a/b", "a/b", 0};
        vecs[2] = '{"block_mix", "x/*y*/;/**//* a **/", "x ;  ", 3};
        vecs[4] = '{"star_run", "a/*b*c**/d", "a d", 1};
        vecs[5] = '{"two_flush", "/x/y", "/x/y", 0};
        vecs[6] = '{"pending_slash", "a/", "a", 0};
        vecs[7] = '{"slash_in_block", "/*/ */e", " e", 1};
        vecs[8] = '{"nl_in_block", nl_blk, " ", 1};
`ifdef COMMENT_STRIP_LINE_EN
        vecs[3]  = '{"line", "//c\ni;", "\ni;", 1};
        vecs[9]  = '{"line_pending", "a//b", "a", 0};
        vecs[10] = '{"triple_slash", "///*x*/", "", 0};
`else
        vecs[3]  = '{"line_off", "//c\ni;", "//c\ni;", 0};
        vecs[9]  = '{"dslash_off", "a//b", "a//b", 0};
        vecs[10] = '{"triple_slash", "///*x*/", "// ", 1};
`endif

        // reset values
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_in_comment", in_comment, 0);
        check("rst_cnt", comment_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // table-driven vectors
        for (int v = 0; v < 11; v++) begin
            do_reset();
            send_str(vecs[v].stim);
            idle(4);
            str_to_exp(vecs[v].exp);
            check_out(vecs[v].name);
            check({vecs[v].name, "_cnt"}, comment_cnt, vecs[v].cnt);
        end

        // continuous stream: each char out exactly one cycle after acceptance
        do_reset();
        send("i");
        check("lat_valid", out_valid, 1);
        check("lat_char", out_char, "i");
        send("n");
        check("lat_char2", out_char, "n");
        check("lat_ready", in_ready, 1);
        idle(1);
        check("lat_idle_valid", out_valid, 0);

        // flush timing and source hold
        do_reset();
        send("a");
        send("/");
        check("slash_silent", out_valid, 0);
        send("b");
        check("flush1_char", out_char, "/");
        check("flush1_valid", out_valid, 1);
        check("flush1_ready", in_ready, 0);
        in_char = "c";
        @(posedge clk);
        #1;
        check("flush2_char", out_char, "b");
        check("flush2_valid", out_valid, 1);
        check("flush2_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("flush3_char", out_char, "c");
        idle(3);
        str_to_exp("a/bc");
        check_out("flush_stream");

        // in_comment window
        do_reset();
        send("/");
        check("incm_slash", in_comment, 0);
        send("*");
        check("incm_open", in_comment, 1);
        send("*");
        check("incm_bstar", in_comment, 1);
        send("/");
        check("incm_close", in_comment, 0);
        check("incm_close_char", out_char, 8'h20);
        check("incm_close_cnt", comment_cnt, 1);
`ifdef COMMENT_STRIP_LINE_EN
        send("/");
        send("/");
        check("incm_line_open", in_comment, 1);
        send(8'h0A);
        check("incm_line_close", in_comment, 0);
        check("incm_line_char", out_char, 8'h0A);
        check("incm_line_cnt", comment_cnt, 2);
`endif
        idle(2);

        // reset inside a block comment
        do_reset();
        send_str("/* q");
        do_reset();
        send("i");
        idle(3);
        str_to_exp("i");
        check_out("rst_block_stream");
        check("rst_block_cnt", comment_cnt, 0);

        // reset with a '/' held
        do_reset();
        send("/");
        idle(2);
        do_reset();
        idle(3);
        check("rst_slash_silent", got_q.size(), 0);
        send("a");
        idle(2);
        str_to_exp("a");
        check_out("rst_slash_stream");

        // reset in FLUSH drops the held character
        do_reset();
        send("/");
        send("q");
        do_reset();
        check("rst_flush_char", out_char, 0);
        check("rst_flush_ready", in_ready, 1);
        idle(3);
        check("rst_flush_silent", got_q.size(), 0);

        // counter saturation
        do_reset();
        for (int k = 0; k < 254; k++) send_str("/**/");
        idle(2);
        check("sat_254", comment_cnt, 254);
        send_str("/**/");
        idle(2);
        check("sat_255", comment_cnt, 255);
        for (int k = 0; k < 5; k++) send_str("/**/");
        idle(2);
        check("sat_hold", comment_cnt, 255);
        check("sat_spaces", got_q.size(), 260);

        // random streams against the model
        alpha[0] = "a";
        alpha[1] = "/";
        alpha[2] = "*";
        alpha[3] = 8'h0A;
        alpha[4] = " ";
        for (int r = 0; r < 8; r++) begin
            do_reset();
            stim_q.delete();
            len = $urandom_range(20, 60);
            for (int k = 0; k < len; k++) stim_q.push_back(alpha[$urandom_range(0, 4)]);
            // closes any pending opener, block or line comment
            stim_q.push_back(8'h0A);
            stim_q.push_back("*");
            stim_q.push_back("/");
            stim_q.push_back(8'h0A);
            stim_q.push_back("Z");
            for (int k = 0; k < stim_q.size(); k++) begin
                send(stim_q[k]);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            idle(4);
            model();
            check_out($sformatf("rand%0d_stream", r));
            check($sformatf("rand%0d_cnt", r), comment_cnt, exp_cnt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
